// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings
// and byte-lane constants.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [3:0] SEL_ALL  = 4'hF;
   localparam logic [3:0] SEL_NONE = 4'h0;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 synchronous RAM with four byte write-enables and a registered
// read port. The read register only loads on rd_en, so it holds the last
// word read; rd_clr forces it to zero (reset, or an errored read).
module dmem_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] adr,
   input  logic [3:0]            be,
   input  logic [31:0]           din,
   input  logic                  rd_en,
   input  logic                  rd_clr,
   output logic [31:0]           dout
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0] mem [DEPTH];

   // Byte-lane writes: only lanes with an enable set are touched.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (be[k]) begin
            mem[adr][8*k +: 8] <= din[8*k +: 8];
         end
      end
   end

   // Registered read port; holds its value between reads.
   always_ff @(posedge clk) begin
      if (rd_clr) begin
         dout <= '0;
      end else if (rd_en) begin
         dout <= mem[adr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder (slave end of the CPU data bus).
// Captures one request in IDLE, waits WAIT_CYCLES, performs the RAM access
// on the edge entering ACK and pulses o_ack for one cycle.
// Optional build macro DMEM_ACCESS_ERR_EN adds o_err and rejects addresses
// with any bit set above ADDR_WIDTH; without it those bits alias.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_WIDTH   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [29:0] i_adr,
   input  logic [3:0]  i_sel,
   input  logic        i_we,
   input  logic        i_re,
   input  logic [31:0] i_din,
   output logic [31:0] o_dout,
`ifdef DMEM_ACCESS_ERR_EN
   output logic        o_err,
`endif
   output logic        o_ack
);

   localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   req_new;

   // Request latches (data only, no reset needed).
   logic [ADDR_WIDTH-1:0]  adr_q;
   logic [3:0]             sel_q;
   logic [31:0]            din_q;
   logic                   we_q;

   // Effective request: live inputs while in IDLE (zero-wait case enters ACK
   // on the capture edge), latched copy afterwards.
   logic [ADDR_WIDTH-1:0]  eff_adr;
   logic [3:0]             eff_sel;
   logic [31:0]            eff_din;
   logic                   eff_we;
   logic                   eff_bad;

   logic                   enter_ack;
   logic [3:0]             wr_be;
   logic                   rd_en;
   logic                   rd_clr;

   assign req_new = (state == IDLE) && (i_we || i_re);

`ifdef DMEM_ACCESS_ERR_EN
   logic hi_in;
   logic hi_q;

   assign hi_in = |i_adr[29:ADDR_WIDTH];

   // Latch the out-of-range flag alongside the rest of the request.
   always_ff @(posedge i_clk) begin
      if (req_new) begin
         hi_q <= hi_in;
      end
   end

   assign eff_bad = (state == IDLE) ? hi_in : hi_q;
   assign o_err   = (state == ACK) && hi_q;
`else
   logic unused_adr_hi;

   assign unused_adr_hi = ^i_adr[29:ADDR_WIDTH];
   assign eff_bad       = 1'b0;
`endif

   // Select live or latched request fields.
   always_comb begin
      eff_adr = adr_q;
      eff_sel = sel_q;
      eff_din = din_q;
      eff_we  = we_q;
      if (state == IDLE) begin
         eff_adr = i_adr[ADDR_WIDTH-1:0];
         eff_sel = i_sel;
         eff_din = i_din;
         eff_we  = i_we;
      end
   end

   // Next-state logic; reset overrides everything so an interrupted access
   // never reaches ACK and never writes the RAM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_we || i_re) begin
               state_nxt = (WAIT_CYCLES == 0) ? ACK : WAIT;
            end
         end
         WAIT: begin
            if (cnt <= CNT_ONE) begin
               state_nxt = ACK;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (i_rst) begin
         state_nxt = IDLE;
      end
   end

   // State register and wait counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (req_new) begin
            cnt <= WAIT_LOAD;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   // Capture the request when it is first seen in IDLE.
   always_ff @(posedge i_clk) begin
      if (req_new) begin
         adr_q <= eff_adr;
         sel_q <= i_sel;
         din_q <= i_din;
         we_q  <= i_we;
      end
   end

   assign enter_ack = (state_nxt == ACK);
   assign wr_be     = (enter_ack && eff_we && !eff_bad) ? eff_sel : SEL_NONE;
   assign rd_en     = enter_ack && !eff_we && !eff_bad;
   assign rd_clr    = i_rst || (enter_ack && !eff_we && eff_bad);
   assign o_ack     = (state == ACK);

   dmem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk    (i_clk),
      .adr    (eff_adr),
      .be     (wr_be),
      .din    (eff_din),
      .rd_en  (rd_en),
      .rd_clr (rd_clr),
      .dout   (o_dout)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with different WAIT_CYCLES and
// ADDR_WIDTH, a reference memory model and an expected-response queue.
module tb_dmem_responder;

   localparam int N = 4;

   function automatic int aw_of(input int g);
      case (g)
         3:       return 4;
         default: return 10;
      endcase
   endfunction

   function automatic int wc_of(input int g);
      case (g)
         1:       return 0;
         2:       return 3;
         default: return 1;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] adr  [N];
   logic [3:0]  sel  [N];
   logic        we   [N];
   logic        re   [N];
   logic [31:0] din  [N];
   logic [31:0] dout [N];
   logic        ack  [N];
`ifdef DMEM_ACCESS_ERR_EN
   logic        err  [N];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
         .ADDR_WIDTH  (aw_of(g)),
         .WAIT_CYCLES (wc_of(g)),
         .CNT_WIDTH   (4)
      ) u_dut (
         .i_clk  (clk),
         .i_rst  (rst),
         .i_adr  (adr[g]),
         .i_sel  (sel[g]),
         .i_we   (we[g]),
         .i_re   (re[g]),
         .i_din  (din[g]),
         .o_dout (dout[g]),
`ifdef DMEM_ACCESS_ERR_EN
         .o_err  (err[g]),
`endif
         .o_ack  (ack[g])
      );
   end

   typedef struct {
      int          idx;
      logic [31:0] dout;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mdl [int];
   logic [31:0] last_dout [N];
   int          ack_seen [N];
   int          ack_issued [N];
   int          ack_cycle [N];
   int          cycle = 0;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (ack[i] === 1'b1) ack_seen[i] <= ack_seen[i] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int key_of(input int g, input logic [29:0] a);
      logic [29:0] mask;
      mask = (30'd1 << aw_of(g)) - 30'd1;
      return (g << 16) | int'(a & mask);
   endfunction

   // One complete access: update model, queue expectation, drive, wait for
   // the ack (bounded), compare, then hold the request through the ACK cycle.
   task automatic access(input int g, input logic w, input logic r,
                         input logic [29:0] a, input logic [3:0] s,
                         input logic [31:0] d, input bit drop, input string tag);
      exp_t        e;
      bit          bad;
      int          k;
      int          n;
      logic [31:0] m;
      bad = 1'b0;
`ifdef DMEM_ACCESS_ERR_EN
      bad = (a >> aw_of(g)) != 30'd0;
`endif
      k = key_of(g, a);
      if (w) begin
         if (!bad) begin
            m = mdl.exists(k) ? mdl[k] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            mdl[k] = m;
         end
      end else begin
         last_dout[g] = bad ? 32'h0 : (mdl.exists(k) ? mdl[k] : 32'h0);
      end
      e.idx  = g;
      e.dout = last_dout[g];
      e.err  = bad;
      sb.push_back(e);
      ack_issued[g]++;
      we[g] = w; re[g] = r; adr[g] = a; sel[g] = s; din[g] = d;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (ack[g] === 1'b1) break;
         n++;
         if (n > 40) break;
         if (drop && n == 1) begin
            @(posedge clk);
            #1;
            we[g] = 1'b0; re[g] = 1'b0;
            adr[g] = 30'($urandom); sel[g] = 4'($urandom); din[g] = $urandom;
         end
      end
      check({tag, "_lat"}, n, 1 + wc_of(g));
      e = sb.pop_front();
      if (ack[g] === 1'b1) begin
         check({tag, "_dout"}, dout[g], e.dout);
`ifdef DMEM_ACCESS_ERR_EN
         check({tag, "_err"}, {31'd0, err[g]}, {31'd0, e.err});
`endif
      end
      ack_cycle[g] = cycle;
      @(posedge clk);
      #1;
      we[g] = 1'b0; re[g] = 1'b0;
   endtask

   initial begin
      int prev;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         adr[i] = '0; sel[i] = '0; we[i] = 1'b0; re[i] = 1'b0; din[i] = '0;
         last_dout[i] = '0; ack_issued[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst_ack%0d", i), {31'd0, ack[i]}, 32'd0);
         check($sformatf("rst_dout%0d", i), dout[i], 32'd0);
`ifdef DMEM_ACCESS_ERR_EN
         check($sformatf("rst_err%0d", i), {31'd0, err[i]}, 32'd0);
`endif
      end
      @(posedge clk);
      #1;

      // WAIT_CYCLES=1: full write, read back, byte write, empty-lane write
      access(0, 1, 0, 30'h010, 4'b1111, 32'hDEADBEEF, 0, "w_full");
      access(0, 0, 1, 30'h010, 4'b0000, 32'h0,       0, "r_full");
      access(0, 1, 0, 30'h010, 4'b0100, 32'h00AA0000, 0, "w_byte");
      access(0, 0, 1, 30'h010, 4'b0001, 32'h0,       0, "r_byte");
      prev = ack_cycle[0];
      access(0, 1, 0, 30'h010, 4'b0000, 32'hFFFFFFFF, 0, "w_none");
      check("period", ack_cycle[0] - prev, 3);
      access(0, 0, 1, 30'h010, 4'b1111, 32'h0,       0, "r_none");

      // WAIT_CYCLES=0
      access(1, 1, 0, 30'h005, 4'b1111, 32'h12345678, 0, "w0_wr");
      access(1, 0, 1, 30'h005, 4'b1111, 32'h0,       0, "w0_rd");

      // WAIT_CYCLES=3, we&re together, request dropped during WAIT
      access(2, 1, 0, 30'h007, 4'b1111, 32'hCAFEF00D, 0, "w3_wr");
      access(2, 0, 1, 30'h007, 4'b1111, 32'h0,       0, "w3_rd");
      access(2, 1, 1, 30'h007, 4'b0011, 32'h0000BEEF, 0, "w3_both");
      access(2, 0, 1, 30'h007, 4'b1111, 32'h0,       0, "w3_rd2");
      access(2, 1, 0, 30'h008, 4'b1111, 32'h76543210, 1, "w3_drop");
      access(2, 0, 1, 30'h008, 4'b1111, 32'h0,       0, "w3_rd3");

      // Reset in WAIT of a write aborts it
      access(0, 1, 0, 30'h020, 4'b1111, 32'h11111111, 0, "pre_rst");
      access(0, 0, 1, 30'h020, 4'b1111, 32'h0,       0, "pre_rd");
      we[0] = 1'b1; adr[0] = 30'h020; sel[0] = 4'hF; din[0] = 32'h22222222;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; we[0] = 1'b0;
      for (int i = 0; i < N; i++) last_dout[i] = '0;
      @(negedge clk);
      check("mid_rst_ack", {31'd0, ack[0]}, 32'd0);
      check("mid_rst_dout", dout[0], 32'd0);
      @(posedge clk);
      #1;
      access(0, 0, 1, 30'h020, 4'b1111, 32'h0, 0, "post_rst");

      // ADDR_WIDTH=4: upper address bits alias or error
      access(3, 1, 0, 30'h000, 4'b1111, 32'h01234567, 0, "aw_init");
      access(3, 1, 0, 30'h020, 4'b1111, 32'h5A5A5A5A, 0, "aw_hi_wr");
      access(3, 0, 1, 30'h000, 4'b1111, 32'h0,       0, "aw_lo_rd");
      access(3, 0, 1, 30'h020, 4'b1111, 32'h0,       0, "aw_hi_rd");

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("ack_count%0d", i), ack_seen[i], ack_issued[i]);
      end
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
